// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt pending/handshake controller.
package irq_pkg;

    localparam int NUM_IRQ = 8;
    localparam int VEC_W   = 3;

    // Every source is rising-edge latched unless the instance says otherwise.
    localparam logic [NUM_IRQ-1:0] DEFAULT_EDGE_MASK = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    // One-hot select of a single source from its binary index.
    function automatic logic [NUM_IRQ-1:0] vec_to_onehot(input logic [VEC_W-1:0] idx);
        logic [NUM_IRQ-1:0] onehot;
        onehot      = '0;
        onehot[idx] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Single-bit synchroniser for one raw interrupt source, followed by a
// history flop so the owner can detect a rising edge on the synced level.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic [SYNC_STAGES-1:0] chain_d;
    logic                   prev_q;

    assign chain_d = {chain_q[SYNC_STAGES-2:0], async_i};

    // Shift the raw input through the metastability chain and remember the last synced level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= chain_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = chain_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~prev_q;

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt capture and CPU handshake stage in front of an 8:3 active-low
// priority encoder. Raw sources are synchronised, latched as pending (edge or
// level per source), masked toward the encoder, and the encoder's answer is
// turned into an irq/ack/eoi handshake with the CPU.
// Optional build macro IRQ_ACK_TIMEOUT_EN adds an ack watchdog and the
// ack_timeout output; without it REQ waits for the CPU indefinitely.
module irq_pending_ctrl
    import irq_pkg::*;
#(
    parameter int                  SYNC_STAGES    = 2,
    parameter logic [NUM_IRQ-1:0]  EDGE_MASK      = DEFAULT_EDGE_MASK,
    parameter int                  TIMEOUT_CYCLES = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] mask,
    output logic [NUM_IRQ-1:0] enc_in_n,
    output logic               enc_en_n,
    input  logic [VEC_W-1:0]   enc_code_n,
    input  logic               enc_gs_n,
    output logic               cpu_irq,
    input  logic               cpu_ack,
    input  logic               cpu_eoi,
    output logic [VEC_W-1:0]   cpu_vec,
    output logic               vec_valid,
    output logic               vec_spurious,
`ifdef IRQ_ACK_TIMEOUT_EN
    output logic               ack_timeout,
`endif
    output logic [NUM_IRQ-1:0] pending
);

    logic [NUM_IRQ-1:0] sync_w;
    logic [NUM_IRQ-1:0] rise_w;

    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] pending_d;
    logic [NUM_IRQ-1:0] edge_pend;
    logic [NUM_IRQ-1:0] clear_vec;

    state_t             state_q;
    state_t             state_d;
    logic               cpu_irq_q;
    logic               cpu_irq_d;
    logic [VEC_W-1:0]   cpu_vec_q;
    logic [VEC_W-1:0]   cpu_vec_d;
    logic               vec_valid_q;
    logic               vec_valid_d;
    logic               vec_spurious_q;
    logic               vec_spurious_d;

`ifdef IRQ_ACK_TIMEOUT_EN
    localparam int               WD_W     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_q;
    logic [WD_W-1:0] wd_cnt_d;
    logic            ack_timeout_q;
    logic            ack_timeout_d;
`else
    // The watchdog is compiled out; the limit stays a parameter so both builds share one interface.
    localparam int timeout_cycles_unused = TIMEOUT_CYCLES;
`endif

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
        irq_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk     (clk),
            .rst_n   (rst_n),
            .async_i (irq_in[g]),
            .sync_o  (sync_w[g]),
            .rise_o  (rise_w[g])
        );
    end

    // Edge sources: a fresh edge is applied after the service clear so a
    // coincident edge keeps the request alive. Level sources simply follow
    // the synced input every cycle and ignore the clear.
    assign edge_pend = (pending_q & ~clear_vec) | rise_w;
    assign pending_d = (EDGE_MASK & edge_pend) | (~EDGE_MASK & sync_w);

    // Handshake FSM: raise cpu_irq when the encoder reports a request, capture
    // the vector on ack, and hold the encoder disabled until end-of-interrupt.
    always_comb begin
        state_d        = state_q;
        cpu_irq_d      = cpu_irq_q;
        cpu_vec_d      = cpu_vec_q;
        vec_valid_d    = vec_valid_q;
        vec_spurious_d = vec_spurious_q;
        clear_vec      = '0;
`ifdef IRQ_ACK_TIMEOUT_EN
        wd_cnt_d       = '0;
        ack_timeout_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (!enc_gs_n) begin
                    state_d   = REQ;
                    cpu_irq_d = 1'b1;
                end
            end
            REQ: begin
                if (cpu_ack) begin
                    cpu_irq_d = 1'b0;
                    if (!enc_gs_n) begin
                        cpu_vec_d      = ~enc_code_n;
                        vec_valid_d    = 1'b1;
                        vec_spurious_d = 1'b0;
                        clear_vec      = vec_to_onehot(~enc_code_n) & EDGE_MASK;
                        state_d        = SERVICE;
                    end else begin
                        cpu_vec_d      = '0;
                        vec_valid_d    = 1'b0;
                        vec_spurious_d = 1'b1;
                        state_d        = IDLE;
                    end
                end
`ifdef IRQ_ACK_TIMEOUT_EN
                else if (wd_cnt_q == WD_LIMIT) begin
                    cpu_irq_d     = 1'b0;
                    ack_timeout_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
`endif
            end
            SERVICE: begin
                if (cpu_eoi) begin
                    vec_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                cpu_irq_d = 1'b0;
            end
        endcase
    end

    // State, pending bits and all CPU-facing outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            pending_q      <= '0;
            cpu_irq_q      <= 1'b0;
            cpu_vec_q      <= '0;
            vec_valid_q    <= 1'b0;
            vec_spurious_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            cpu_irq_q      <= cpu_irq_d;
            cpu_vec_q      <= cpu_vec_d;
            vec_valid_q    <= vec_valid_d;
            vec_spurious_q <= vec_spurious_d;
        end
    end

`ifdef IRQ_ACK_TIMEOUT_EN
    // Watchdog counts REQ cycles and produces a one-cycle timeout pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q      <= '0;
            ack_timeout_q <= 1'b0;
        end else begin
            wd_cnt_q      <= wd_cnt_d;
            ack_timeout_q <= ack_timeout_d;
        end
    end

    assign ack_timeout = ack_timeout_q;
`endif

    assign enc_in_n     = ~(pending_q & mask);
    assign enc_en_n     = (state_q == SERVICE);
    assign cpu_irq      = cpu_irq_q;
    assign cpu_vec      = cpu_vec_q;
    assign vec_valid    = vec_valid_q;
    assign vec_spurious = vec_spurious_q;
    assign pending      = pending_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Self-checking bench for irq_pending_ctrl. Source 0 is configured as a level
// source, all others edge-triggered; a behavioural 8:3 active-low priority
// encoder closes the loop. Handshake outcomes go through a scoreboard queue.
module tb_irq_pending_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irq_in;
    logic [7:0] mask;
    logic [7:0] enc_in_n;
    logic       enc_en_n;
    logic [2:0] enc_code_n;
    logic       enc_gs_n;
    logic       cpu_irq;
    logic       cpu_ack;
    logic       cpu_eoi;
    logic [2:0] cpu_vec;
    logic       vec_valid;
    logic       vec_spurious;
    logic [7:0] pending;
`ifdef IRQ_ACK_TIMEOUT_EN
    logic       ack_timeout;
`endif

    int checkCount = 0;
    int passCount  = 0;

    typedef struct packed {
        logic [2:0] vec;
        logic       valid;
        logic       spur;
        logic       irq;
        logic       enN;
        logic [7:0] pend;
    } expect_t;

    expect_t expectQ[$];

    logic [2:0] encIdx;
    logic       anyReq;

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    irq_pending_ctrl #(
        .SYNC_STAGES    (2),
        .EDGE_MASK      (8'hFE),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_in       (irq_in),
        .mask         (mask),
        .enc_in_n     (enc_in_n),
        .enc_en_n     (enc_en_n),
        .enc_code_n   (enc_code_n),
        .enc_gs_n     (enc_gs_n),
        .cpu_irq      (cpu_irq),
        .cpu_ack      (cpu_ack),
        .cpu_eoi      (cpu_eoi),
        .cpu_vec      (cpu_vec),
        .vec_valid    (vec_valid),
        .vec_spurious (vec_spurious),
`ifdef IRQ_ACK_TIMEOUT_EN
        .ack_timeout  (ack_timeout),
`endif
        .pending      (pending)
    );

    // Behavioural active-low 8:3 priority encoder: highest low input wins,
    // all outputs high when disabled or idle.
    always_comb begin
        encIdx = 3'd0;
        anyReq = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!enc_in_n[i]) begin
                encIdx = 3'(i);
                anyReq = 1'b1;
            end
        end
        enc_gs_n   = enc_en_n | ~anyReq;
        enc_code_n = enc_gs_n ? 3'b111 : ~encIdx;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic expect_t mkExp(input logic [2:0] vec, input logic valid, input logic spur,
                                      input logic irq, input logic enN, input logic [7:0] pend);
        expect_t e;
        e.vec = vec; e.valid = valid; e.spur = spur; e.irq = irq; e.enN = enN; e.pend = pend;
        return e;
    endfunction

    task automatic compareNext(input string tag);
        expect_t e;
        e = expectQ.pop_front();
        checkOutput({tag, ".vec"},   32'(cpu_vec),      32'(e.vec));
        checkOutput({tag, ".valid"}, 32'(vec_valid),    32'(e.valid));
        checkOutput({tag, ".spur"},  32'(vec_spurious), 32'(e.spur));
        checkOutput({tag, ".irq"},   32'(cpu_irq),      32'(e.irq));
        checkOutput({tag, ".enN"},   32'(enc_en_n),     32'(e.enN));
        checkOutput({tag, ".pend"},  32'(pending),      32'(e.pend));
    endtask

    // Drive one handshake cycle, queue what it should produce, then compare.
    task automatic applyStimulus(input string tag, input logic ack, input logic eoi, input expect_t e);
        cpu_ack = ack;
        cpu_eoi = eoi;
        expectQ.push_back(e);
        tick();
        cpu_ack = 1'b0;
        cpu_eoi = 1'b0;
        compareNext(tag);
    endtask

    // One-cycle pulse on raw sources; the pulse is sampled at the next edge.
    task automatic pulseIrq(input logic [7:0] bits);
        irq_in = irq_in | bits;
        tick();
        irq_in = irq_in & ~bits;
    endtask

    task automatic doReset();
        rst_n   = 1'b0;
        irq_in  = 8'h00;
        mask    = 8'hFF;
        cpu_ack = 1'b0;
        cpu_eoi = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        doReset();

        // Reset state, then idle with no sources.
        checkOutput("rst.enc_in_n", 32'(enc_in_n), 32'hFF);
        checkOutput("rst.enc_en_n", 32'(enc_en_n), 32'h0);
        checkOutput("rst.cpu_irq",  32'(cpu_irq),  32'h0);
        checkOutput("rst.cpu_vec",  32'(cpu_vec),  32'h0);
        checkOutput("rst.valid",    32'(vec_valid), 32'h0);
        checkOutput("rst.spur",     32'(vec_spurious), 32'h0);
        checkOutput("rst.pending",  32'(pending),  32'h00);
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("idle.cpu_irq",  32'(cpu_irq),  32'h0);
            checkOutput("idle.enc_in_n", 32'(enc_in_n), 32'hFF);
        end

        // Single edge source: latency and full handshake.
        pulseIrq(8'h20);
        checkOutput("lat.pend_e1", 32'(pending), 32'h00);
        tick();
        checkOutput("lat.pend_e2", 32'(pending), 32'h00);
        tick();
        checkOutput("lat.pend_e3", 32'(pending), 32'h20);
        checkOutput("lat.irq_e3",  32'(cpu_irq), 32'h0);
        tick();
        checkOutput("lat.irq_e4",  32'(cpu_irq), 32'h1);
        checkOutput("lat.enc_in",  32'(enc_in_n), 32'hDF);
        applyStimulus("t2_ack", 1'b1, 1'b0, mkExp(3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00));
        applyStimulus("t2_eoi", 1'b0, 1'b1, mkExp(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        tick();
        checkOutput("t2.irq_quiet", 32'(cpu_irq), 32'h0);

        // Two pending sources: priority order then the remaining one.
        pulseIrq(8'h24);
        repeat (3) tick();
        checkOutput("t3.pend", 32'(pending), 32'h24);
        checkOutput("t3.irq",  32'(cpu_irq), 32'h1);
        applyStimulus("t3_ack5", 1'b1, 1'b0, mkExp(3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 8'h04));
        applyStimulus("t3_eoi5", 1'b0, 1'b1, mkExp(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h04));
        tick();
        checkOutput("t3.irq_again", 32'(cpu_irq), 32'h1);
        applyStimulus("t3_ack2", 1'b1, 1'b0, mkExp(3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00));
        applyStimulus("t3_eoi2", 1'b0, 1'b1, mkExp(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));

        // Level source 0 held high: not cleared by ack, re-asserts after eoi.
        irq_in[0] = 1'b1;
        repeat (3) tick();
        checkOutput("t4.pend", 32'(pending), 32'h01);
        tick();
        checkOutput("t4.irq",  32'(cpu_irq), 32'h1);
        applyStimulus("t4_ack", 1'b1, 1'b0, mkExp(3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01));
        tick();
        checkOutput("t4.pend_service", 32'(pending), 32'h01);
        applyStimulus("t4_eoi", 1'b0, 1'b1, mkExp(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01));
        tick();
        checkOutput("t4.irq_reassert", 32'(cpu_irq), 32'h1);
        applyStimulus("t4_ack2", 1'b1, 1'b0, mkExp(3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01));
        irq_in[0] = 1'b0;
        repeat (3) tick();
        checkOutput("t4.pend_drop", 32'(pending), 32'h00);
        applyStimulus("t4_eoi2", 1'b0, 1'b1, mkExp(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        tick();
        checkOutput("t4.irq_quiet", 32'(cpu_irq), 32'h0);

        // Mask removed before ack: spurious ack, pending untouched.
        pulseIrq(8'h08);
        repeat (3) tick();
        checkOutput("t5.irq", 32'(cpu_irq), 32'h1);
        mask = 8'hF7;
        #1;
        checkOutput("t5.enc_masked", 32'(enc_in_n), 32'hFF);
        applyStimulus("t5_spur", 1'b1, 1'b0, mkExp(3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h08));
        tick();
        checkOutput("t5.irq_idle", 32'(cpu_irq), 32'h0);
        mask = 8'hFF;
        #1;
        checkOutput("t5.enc_unmasked", 32'(enc_in_n), 32'hF7);
        tick();
        checkOutput("t5.irq_again", 32'(cpu_irq), 32'h1);
        applyStimulus("t5_ack", 1'b1, 1'b0, mkExp(3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00));
        applyStimulus("t5_eoi", 1'b0, 1'b1, mkExp(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));

        // Ignored strobes, simultaneous ack/eoi, and set-wins-over-clear.
        applyStimulus("t6_ack_idle", 1'b1, 1'b0, mkExp(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        pulseIrq(8'h40);
        repeat (3) tick();
        applyStimulus("t6_eoi_req", 1'b0, 1'b1, mkExp(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h40));
        pulseIrq(8'h40);
        tick();
        applyStimulus("t6_set_wins", 1'b1, 1'b1, mkExp(3'd6, 1'b1, 1'b0, 1'b0, 1'b1, 8'h40));
        applyStimulus("t6_both_svc", 1'b1, 1'b1, mkExp(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 8'h40));
        tick();
        checkOutput("t6.irq_again", 32'(cpu_irq), 32'h1);
        applyStimulus("t6_ack", 1'b1, 1'b0, mkExp(3'd6, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00));
        applyStimulus("t6_eoi", 1'b0, 1'b1, mkExp(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));

        // Asynchronous reset in the middle of a cycle drops everything.
        pulseIrq(8'h82);
        repeat (3) tick();
        checkOutput("t7.irq", 32'(cpu_irq), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t7.pend_rst", 32'(pending),  32'h00);
        checkOutput("t7.irq_rst",  32'(cpu_irq),  32'h0);
        checkOutput("t7.enc_rst",  32'(enc_in_n), 32'hFF);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("t7.irq_after", 32'(cpu_irq), 32'h0);
        checkOutput("t7.pend_after", 32'(pending), 32'h00);

`ifdef IRQ_ACK_TIMEOUT_EN
        // Watchdog: no ack for TIMEOUT_CYCLES REQ cycles, then retry.
        begin
            int held;
            pulseIrq(8'h10);
            repeat (3) tick();
            checkOutput("t8.irq", 32'(cpu_irq), 32'h1);
            held = 0;
            while (cpu_irq && held < 40) begin
                tick();
                held++;
            end
            checkOutput("t8.req_cycles", 32'(held), 32'd16);
            checkOutput("t8.timeout",    32'(ack_timeout), 32'h1);
            checkOutput("t8.pend_kept",  32'(pending), 32'h10);
            tick();
            checkOutput("t8.timeout_end", 32'(ack_timeout), 32'h0);
            checkOutput("t8.irq_retry",   32'(cpu_irq), 32'h1);
            applyStimulus("t8_ack", 1'b1, 1'b0, mkExp(3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00));
            applyStimulus("t8_eoi", 1'b0, 1'b1, mkExp(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        end
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] simulation time limit");
    end

endmodule
